fp16_operand_classifier: RTL and testbench

//  Input stage of the fp16 MAC lane: accepts operand pairs via valid/ready, decodes each into a
//  6-bit one-hot class, and presents registered {TYPES, F} to the extreme-value detector and the

---
 rtl/fp16_operand_classifier.sv | 153 +++++++++++++++
 tb/tb_fp16_operand_classifier.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fp16_operand_classifier.sv
// Input stage of the fp16 MAC lane: classifies operand pairs and registers them through a 2-entry skid buffer.
// Latency 1 cycle when empty; S_READY is registered and drops only when both MAIN and SKID hold a pair.
module fp16_operand_classifier #(
  parameter logic FTZ      = 1'b0,
  parameter logic EN_FLAGS = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             S_VALID,
  output logic             S_READY,
  input  logic [15:0]      S_A,
  input  logic [15:0]      S_B,
  output logic             M_VALID,
  input  logic             M_READY,
  output logic [1:0][5:0]  TYPES,
  output logic [1:0][15:0] F,
  output logic             FLAG_INV,
  output logic             FLAG_SUB,
  input  logic             FLAG_CLR
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  // One-hot class: 5 normal, 4 subnormal, 3 zero, 2 inf, 1 qNaN, 0 sNaN
  function automatic logic [5:0] classify(input logic [15:0] x);
    logic [5:0] c;
    c = 6'b100000;
    if (x[14:10] == 5'd0) begin
      c = (x[9:0] == 10'd0) ? 6'b001000 : 6'b010000;
    end else if (x[14:10] == 5'h1f) begin
      if (x[9:0] == 10'd0) c = 6'b000100;
      else if (x[9])       c = 6'b000010;
      else                 c = 6'b000001;
    end
    return c;
  endfunction

  logic [1:0][15:0] op;
  logic [1:0][5:0]  raw_types;
  logic [1:0][5:0]  in_types;
  logic [1:0][15:0] in_f;

  assign op = {S_B, S_A};

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      raw_types[i] = classify(op[i]);
      in_types[i]  = raw_types[i];
      in_f[i]      = op[i];
      if (FTZ && raw_types[i][4]) begin
        in_types[i] = 6'b001000;
        in_f[i]     = {op[i][15], 15'h0};
      end
    end
  end

  state_t           state, next_state;
  logic             ready_q;
  logic [1:0][5:0]  main_types, skid_types;
  logic [1:0][15:0] main_f, skid_f;
  logic             acc_in, acc_out;
  logic             load_main_in, load_main_skid, load_skid;

  // Reset gates S_READY so nothing is accepted during a reset cycle
  assign S_READY = ready_q & ~RST;
  assign M_VALID = (state != EMPTY);
  assign acc_in  = S_VALID & S_READY;
  assign acc_out = M_VALID & M_READY;
  assign TYPES   = main_types;
  assign F       = main_f;

  always_comb begin
    next_state     = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      EMPTY: begin
        if (acc_in) begin
          load_main_in = 1'b1;
          next_state   = ONE;
        end
      end
      ONE: begin
        if (acc_in && acc_out) begin
          load_main_in = 1'b1;
        end else if (acc_in) begin
          load_skid  = 1'b1;
          next_state = FULL;
        end else if (acc_out) begin
          next_state = EMPTY;
        end
      end
      FULL: begin
        if (acc_out) begin
          load_main_skid = 1'b1;
          next_state     = ONE;
        end
      end
      default: next_state = EMPTY;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= EMPTY;
      ready_q    <= 1'b0;
      main_types <= '0;
      main_f     <= '0;
      skid_types <= '0;
      skid_f     <= '0;
    end else begin
      state   <= next_state;
      ready_q <= (next_state != FULL);
      if (load_main_in) begin
        main_types <= in_types;
        main_f     <= in_f;
      end else if (load_main_skid) begin
        main_types <= skid_types;
        main_f     <= skid_f;
      end
      if (load_skid) begin
        skid_types <= in_types;
        skid_f     <= in_f;
      end
    end
  end

  generate
    if (EN_FLAGS) begin : g_flags
      logic inv_q, sub_q;
      logic set_inv, set_sub;
      // Flags see the raw classes so FTZ does not hide subnormal inputs
      assign set_inv = acc_in & (raw_types[0][0] | raw_types[1][0]);
      assign set_sub = acc_in & (raw_types[0][4] | raw_types[1][4]);
      always_ff @(posedge CLK) begin
        if (RST) begin
          inv_q <= 1'b0;
          sub_q <= 1'b0;
        end else begin
          inv_q <= set_inv | (inv_q & ~FLAG_CLR);
          sub_q <= set_sub | (sub_q & ~FLAG_CLR);
        end
      end
      assign FLAG_INV = inv_q;
      assign FLAG_SUB = sub_q;
    end else begin : g_no_flags
      assign FLAG_INV = 1'b0;
      assign FLAG_SUB = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_fp16_operand_classifier.sv
// Directed bench for fp16_operand_classifier: scoreboard on the output stream plus targeted checks.
module tb_fp16_operand_classifier;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             s_valid = 1'b0;
  logic [15:0]      s_a = '0, s_b = '0;
  logic             m_ready = 1'b0;
  logic             flag_clr = 1'b0;
  logic             s_ready, m_valid, flag_inv, flag_sub;
  logic [1:0][5:0]  types;
  logic [1:0][15:0] f;
  logic             s_ready_z, m_valid_z, flag_inv_z, flag_sub_z;
  logic [1:0][5:0]  types_z;
  logic [1:0][15:0] f_z;

  int errors = 0;
  int checks = 0;
  int out_cnt = 0;
  logic [43:0] sb_q[$];

  always #5 clk = ~clk;

  fp16_operand_classifier #(.FTZ(1'b0), .EN_FLAGS(1'b1)) u_dut (
    .CLK(clk), .RST(rst), .S_VALID(s_valid), .S_READY(s_ready), .S_A(s_a), .S_B(s_b),
    .M_VALID(m_valid), .M_READY(m_ready), .TYPES(types), .F(f),
    .FLAG_INV(flag_inv), .FLAG_SUB(flag_sub), .FLAG_CLR(flag_clr)
  );

  fp16_operand_classifier #(.FTZ(1'b1), .EN_FLAGS(1'b1)) u_ftz (
    .CLK(clk), .RST(rst), .S_VALID(s_valid), .S_READY(s_ready_z), .S_A(s_a), .S_B(s_b),
    .M_VALID(m_valid_z), .M_READY(m_ready), .TYPES(types_z), .F(f_z),
    .FLAG_INV(flag_inv_z), .FLAG_SUB(flag_sub_z), .FLAG_CLR(flag_clr)
  );

  function automatic logic [5:0] ref_class(input logic [15:0] x);
    if (x[14:10] == 5'h1f) begin
      if (x[9:0] == 10'd0) return 6'h04;
      if (x[9])            return 6'h02;
      return 6'h01;
    end
    if (x[14:10] == 5'h00) return (x[9:0] == 10'd0) ? 6'h08 : 6'h10;
    return 6'h20;
  endfunction

  function automatic logic [43:0] ref_pair(input logic [15:0] a, input logic [15:0] b);
    return {ref_class(b), ref_class(a), b, a};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: push on input handshake, pop on output handshake
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
    end else begin
      if (m_valid && m_ready) begin
        out_cnt++;
        if (sb_q.size() == 0) chk("unexpected_output", {20'd0, types, f}, 64'd0);
        else                  chk("output_pair", {20'd0, types, f}, {20'd0, sb_q.pop_front()});
      end
      if (s_valid && s_ready) sb_q.push_back(ref_pair(s_a, s_b));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b);
    int n;
    n = 0;
    s_valid = 1'b1;
    s_a = a;
    s_b = b;
    @(negedge clk);
    while (!s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("send_accept", {63'd0, s_ready}, 64'd1);
    step();
    s_valid = 1'b0;
  endtask

  initial begin
    int n;
    int cnt0;

    // Reset state
    repeat (3) step();
    @(negedge clk);
    chk("rst_m_valid", {63'd0, m_valid}, 64'd0);
    chk("rst_s_ready", {63'd0, s_ready}, 64'd0);
    chk("rst_types", {52'd0, types}, 64'd0);
    chk("rst_f", {32'd0, f}, 64'd0);
    chk("rst_flags", {62'd0, flag_inv, flag_sub}, 64'd0);
    step();
    rst = 1'b0;
    step();
    @(negedge clk);
    chk("ready_after_rst", {63'd0, s_ready}, 64'd1);

    // Classification of each class pair
    step();
    m_ready = 1'b1;
    send(16'h3C00, 16'h0001);
    @(negedge clk);
    chk("cls1_types", {52'd0, types}, {52'd0, 6'h10, 6'h20});
    step();
    send(16'h7C00, 16'h8000);
    @(negedge clk);
    chk("cls2_types", {52'd0, types}, {52'd0, 6'h08, 6'h04});
    chk("inv_before_snan", {63'd0, flag_inv}, 64'd0);
    step();
    send(16'h7E00, 16'h7D00);
    @(negedge clk);
    chk("cls3_types", {52'd0, types}, {52'd0, 6'h01, 6'h02});
    chk("inv_after_snan", {63'd0, flag_inv}, 64'd1);
    chk("sub_after_0001", {63'd0, flag_sub}, 64'd1);
    step();

    // FTZ instance, starting from cleared flags
    flag_clr = 1'b1;
    step();
    flag_clr = 1'b0;
    @(negedge clk);
    chk("ftz_sub_cleared", {63'd0, flag_sub_z}, 64'd0);
    step();
    send(16'h8001, 16'h3C00);
    @(negedge clk);
    chk("ftz_types0", {58'd0, types_z[0]}, 64'h08);
    chk("ftz_f0", {48'd0, f_z[0]}, 64'h8000);
    chk("ftz_flag_sub", {63'd0, flag_sub_z}, 64'd1);
    step();

    // Flag clear vs set race
    flag_clr = 1'b1;
    step();
    flag_clr = 1'b0;
    @(negedge clk);
    chk("clr_alone_inv", {63'd0, flag_inv}, 64'd0);
    step();
    flag_clr = 1'b1;
    send(16'h7D00, 16'h3C00);
    flag_clr = 1'b0;
    @(negedge clk);
    chk("race_set_wins", {63'd0, flag_inv}, 64'd1);
    step();
    flag_clr = 1'b1;
    step();
    flag_clr = 1'b0;
    @(negedge clk);
    chk("clr_after_race", {63'd0, flag_inv}, 64'd0);
    step();

    // Back-pressure: three back-to-back pairs with a stalled consumer
    m_ready = 1'b0;
    s_valid = 1'b1; s_a = 16'h1111; s_b = 16'h2222;
    @(negedge clk);
    chk("bp_ready_p1", {63'd0, s_ready}, 64'd1);
    step();
    s_a = 16'h3333; s_b = 16'h4444;
    @(negedge clk);
    chk("bp_ready_p2", {63'd0, s_ready}, 64'd1);
    step();
    s_a = 16'h5555; s_b = 16'h6666;
    @(negedge clk);
    chk("bp_ready_full", {63'd0, s_ready}, 64'd0);
    chk("bp_f_head", {32'd0, f}, {32'd0, 16'h2222, 16'h1111});
    step();
    @(negedge clk);
    chk("bp_ready_stall", {63'd0, s_ready}, 64'd0);
    chk("bp_f_stable", {32'd0, f}, {32'd0, 16'h2222, 16'h1111});
    chk("bp_valid_stall", {63'd0, m_valid}, 64'd1);
    step();
    m_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!s_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_p3_accept", {63'd0, s_ready}, 64'd1);
    step();
    s_valid = 1'b0;
    repeat (4) step();
    @(negedge clk);
    chk("bp_drained", sb_q.size(), 64'd0);
    chk("bp_idle", {63'd0, m_valid}, 64'd0);
    step();

    // Streaming at full rate with random operands
    cnt0 = out_cnt;
    for (int i = 0; i < 100; i++) begin
      s_valid = 1'b1;
      s_a = 16'($urandom);
      s_b = 16'($urandom);
      @(negedge clk);
      chk("stream_ready", {63'd0, s_ready}, 64'd1);
      if (i > 0) chk("stream_valid", {63'd0, m_valid}, 64'd1);
      step();
    end
    s_valid = 1'b0;
    @(negedge clk);
    chk("stream_last_valid", {63'd0, m_valid}, 64'd1);
    step();
    @(negedge clk);
    chk("stream_count", out_cnt - cnt0, 64'd100);
    chk("stream_drained", sb_q.size(), 64'd0);
    step();

    // Reset while FULL: stale pairs must vanish
    m_ready = 1'b0;
    send(16'h7D00, 16'h0001);
    send(16'h3C00, 16'h3C00);
    @(negedge clk);
    chk("pre_rst_full", {63'd0, s_ready}, 64'd0);
    chk("pre_rst_inv", {63'd0, flag_inv}, 64'd1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_m_valid", {63'd0, m_valid}, 64'd0);
    chk("mid_rst_s_ready", {63'd0, s_ready}, 64'd0);
    chk("mid_rst_flags", {62'd0, flag_inv, flag_sub}, 64'd0);
    step();
    m_ready = 1'b1;
    repeat (5) step();
    @(negedge clk);
    chk("post_rst_no_stale", {63'd0, m_valid}, 64'd0);
    chk("post_rst_ready", {63'd0, s_ready}, 64'd1);
    chk("final_queue", sb_q.size(), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
